// File: rtl/kyber_pkg.sv
// Shared constants and types for the Kyber NTT datapath blocks.
// Holds the modulus, the final INTT scaling constant, the Barrett
// parameters and the one-hot state encoding of the unload stage.
package kyber_pkg;

   localparam int          COEF_W     = 12;
   localparam int          PROD_W     = 24;
   localparam logic [12:0] Q          = 13'd3329;
   localparam logic [11:0] INV128     = 12'd3303;
   localparam logic [12:0] BARRETT_M  = 13'd5039;
   localparam int          BARRETT_SH = 24;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'b0001,
      ST_RUN   = 4'b0010,
      ST_DRAIN = 4'b0100,
      ST_DONE  = 4'b1000
   } unload_state_t;

endpackage

// File: rtl/kyber_barrett_reduce.sv
// Single registered Barrett reduction stage: x mod q for any x below 2^24.
// The quotient estimate floor(x*m / 2^24) undershoots by at most two,
// so two conditional subtractions of q give the exact residue.
module kyber_barrett_reduce
   import kyber_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              i_valid,
   input  logic [PROD_W-1:0] i_data,
   output logic              o_valid,
   output logic [COEF_W-1:0] o_data
);

   localparam int MUL_W = PROD_W + 13;

   logic [MUL_W-1:0]  w_mulM;
   logic [12:0]       w_quot;
   logic [PROD_W-1:0] w_qExt;
   logic [PROD_W-1:0] w_quotQ;
   logic [PROD_W-1:0] w_rem0;
   logic [PROD_W-1:0] w_rem1;
   logic [PROD_W-1:0] w_rem2;

   // Quotient estimate, partial remainder and the two correction steps
   always_comb begin
      w_qExt  = PROD_W'(Q);
      w_mulM  = MUL_W'(i_data) * MUL_W'(BARRETT_M);
      w_quot  = 13'(w_mulM >> BARRETT_SH);
      w_quotQ = PROD_W'(w_quot) * w_qExt;
      w_rem0  = i_data - w_quotQ;
      w_rem1  = (w_rem0 >= w_qExt) ? (w_rem0 - w_qExt) : w_rem0;
      w_rem2  = (w_rem1 >= w_qExt) ? (w_rem1 - w_qExt) : w_rem1;
   end

   // Register the reduced coefficient together with its valid flag
   always_ff @(posedge clk) begin
      if (reset) begin
         o_valid <= 1'b0;
         o_data  <= '0;
      end else begin
         o_valid <= i_valid;
         o_data  <= COEF_W'(w_rem2);
      end
   end

endmodule

// File: rtl/invntt_unload.sv
// Unload stage behind the inverse NTT: reads the result RAM in address
// order, scales each coefficient by 128^-1 mod q, and streams the results
// out over valid/ready. A credit counter (reads in flight plus FIFO
// occupancy) keeps the small output FIFO from ever overflowing.
module invntt_unload #(
   parameter int DEPTH  = 8,
   parameter int COEF_W = 12,
   parameter int FIFO_D = 4
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              ram_rd_en,
   output logic [DEPTH-1:0]  ram_rd_addr,
   input  logic [COEF_W-1:0] ram_rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [COEF_W-1:0] out_data,
   output logic              out_last,
   output logic              full_out,
   output logic              busy
);

   import kyber_pkg::*;

   localparam int                N          = 1 << DEPTH;
   localparam int                PTR_W      = $clog2(FIFO_D);
   localparam int                CNT_W      = $clog2(FIFO_D + 1);
   localparam logic [CNT_W-1:0]  CREDIT_MAX = CNT_W'(FIFO_D);
   localparam logic [DEPTH-1:0]  LAST_IDX   = DEPTH'(N - 1);

   unload_state_t     r_state;
   logic              r_startQ;
   logic              r_fullOut;
   logic              r_busy;
   logic [DEPTH-1:0]  r_addr;
   logic [DEPTH-1:0]  r_beatIdx;
   logic [CNT_W-1:0]  r_credit;

   logic              r_p0Valid;
   logic              r_p1Valid;
   logic [COEF_W-1:0] r_p1Data;
   logic              r_p2Valid;
   logic [PROD_W-1:0] r_p2Prod;
   logic              w_redValid;
   logic [COEF_W-1:0] w_redData;

   logic [COEF_W-1:0] r_fifoMem [FIFO_D];
   logic [PTR_W-1:0]  r_wrPtr;
   logic [PTR_W-1:0]  r_rdPtr;
   logic [CNT_W-1:0]  r_fifoCnt;

   logic              w_startRise;
   logic              w_fifoEmpty;
   logic [COEF_W-1:0] w_headData;
   logic              w_outValid;
   logic              w_pop;
   logic              w_fifoRd;
   logic              w_fifoWr;
   logic              w_rdEn;

   // Handshake, credit check and FIFO bypass: when the FIFO is empty the
   // freshly reduced beat is presented directly; if it is not taken it is
   // written into the FIFO and shows up unchanged as the head next cycle.
   // A beat leaving this cycle frees its credit for a read this cycle.
   always_comb begin
      w_startRise = start & ~r_startQ;
      w_fifoEmpty = (r_fifoCnt == '0);
      w_headData  = r_fifoMem[r_rdPtr];
      w_outValid  = ~w_fifoEmpty | w_redValid;
      w_pop       = w_outValid & out_ready;
      w_fifoRd    = w_pop & ~w_fifoEmpty;
      w_fifoWr    = w_redValid & ~(w_fifoEmpty & w_pop);
      w_rdEn      = (r_state == ST_RUN) & ((r_credit < CREDIT_MAX) | w_pop);
   end

   assign ram_rd_en   = w_rdEn;
   assign ram_rd_addr = r_addr;
   assign out_valid   = w_outValid;
   assign out_data    = w_outValid ? (w_fifoEmpty ? w_redData : w_headData) : '0;
   assign out_last    = w_outValid & (r_beatIdx == LAST_IDX);
   assign full_out    = r_fullOut;
   assign busy        = r_busy;

   // Control FSM: edge-detects start, walks the read address, waits for
   // the last beat to leave, then holds full_out until start drops
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_startQ  <= 1'b0;
         r_addr    <= '0;
         r_fullOut <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_startQ <= start;
         case (r_state)
            ST_IDLE: begin
               if (w_startRise) begin
                  r_state <= ST_RUN;
                  r_addr  <= '0;
                  r_busy  <= 1'b1;
               end
            end
            ST_RUN: begin
               if (w_rdEn) begin
                  r_addr <= r_addr + 1'b1;
                  if (r_addr == LAST_IDX) begin
                     r_state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (w_pop & out_last) begin
                  r_state   <= ST_DONE;
                  r_fullOut <= 1'b1;
               end
            end
            ST_DONE: begin
               if (!start) begin
                  r_state   <= ST_IDLE;
                  r_fullOut <= 1'b0;
                  r_busy    <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Credits: one taken per read issued, one returned per beat accepted
   always_ff @(posedge clk) begin
      if (reset) begin
         r_credit <= '0;
      end else begin
         r_credit <= r_credit + CNT_W'(w_rdEn) - CNT_W'(w_pop);
      end
   end

   // Read pipeline: RAM latency slot, data capture, scaling product
   always_ff @(posedge clk) begin
      if (reset) begin
         r_p0Valid <= 1'b0;
         r_p1Valid <= 1'b0;
         r_p1Data  <= '0;
         r_p2Valid <= 1'b0;
         r_p2Prod  <= '0;
      end else begin
         r_p0Valid <= w_rdEn;
         r_p1Valid <= r_p0Valid;
         r_p1Data  <= ram_rd_data;
         r_p2Valid <= r_p1Valid;
         r_p2Prod  <= PROD_W'(r_p1Data) * PROD_W'(INV128);
      end
   end

   kyber_barrett_reduce u_reduce (
      .clk     (clk),
      .reset   (reset),
      .i_valid (r_p2Valid),
      .i_data  (r_p2Prod),
      .o_valid (w_redValid),
      .o_data  (w_redData)
   );

   // FIFO pointers, occupancy and the output beat index
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wrPtr   <= '0;
         r_rdPtr   <= '0;
         r_fifoCnt <= '0;
         r_beatIdx <= '0;
      end else begin
         if (w_fifoWr) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_fifoRd) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         r_fifoCnt <= r_fifoCnt + CNT_W'(w_fifoWr) - CNT_W'(w_fifoRd);
         if (w_pop) begin
            r_beatIdx <= r_beatIdx + 1'b1;
         end
      end
   end

   // FIFO storage; stale entries are harmless because pointers are reset
   always_ff @(posedge clk) begin
      if (w_fifoWr) begin
         r_fifoMem[r_wrPtr] <= w_redData;
      end
   end

endmodule

// File: doc/invntt_unload.md
# invntt_unload

Downstream unload stage for the inverse-NTT core. Once the INTT FSM raises `done`, it reads the N result coefficients from the result RAM in address order. It multiplies each coefficient by the final scaling constant 128⁻¹ mod q (3303) and reduces the product exactly modulo q = 3329. The scaled coefficients leave on a valid/ready stream with backpressure, and the block returns `full_out` to the FSM once the last coefficient has been accepted.

## Interface
- `DEPTH`, 8: N = 1 << DEPTH coefficients per polynomial.
- `COEF_W`, 12: coefficient width.
- `FIFO_D`, 4: output FIFO depth; this is also the read-credit limit.
- `clk` input, 1: single clock. All logic is on the rising edge.
- `reset` input, 1: synchronous, active-high reset.
- `start` input, 1: connected to the INTT FSM `done` (level).
- `ram_rd_en` output, 1: result-RAM read strobe.
- `ram_rd_addr` output, DEPTH: result-RAM address.
- `ram_rd_data` input, COEF_W: RAM data, valid 1 cycle after `ram_rd_en`.
- `out_valid` output, 1: output beat valid.
- `out_ready` input, 1: downstream accepts the beat.
- `out_data` output, COEF_W: (coefficient × 3303) mod 3329.
- `out_last` output, 1: high on beat N-1 only.
- `full_out` output, 1: unload complete; goes to the INTT FSM.
- `busy` output, 1: high in any state other than IDLE.

## Operation
- **States:**
  - **IDLE:** a rising edge of `start` (registered `start` = 0, current `start` = 1) moves to RUN and clears the address counter.
  - **RUN:** issues one read per cycle while the credit check passes. After address N-1 is issued, moves to DRAIN.
  - **DRAIN:** waits until beat N-1 is accepted (`out_valid & out_ready & out_last`), then moves to DONE.
  - **DONE:** holds `full_out` = 1 until `start` = 0, then returns to IDLE.
- **Credit rule:** reads are issued only while the in-flight reads plus the FIFO occupancy are less than FIFO_D. The FIFO therefore never overflows, and no write is ever dropped.
- **Pipeline:**
  - P0 drives `ram_rd_en` and the address.
  - P1 registers `ram_rd_data`.
  - P2 registers the 24-bit product (the product is always below 2^24, including for inputs ≥ q).
  - P3 performs the reduction and writes the FIFO.
- **Arithmetic:** `out_data` = (x × 3303) mod 3329, bit-exact for every 12-bit x, inputs 3329..4095 included. A Barrett implementation is permitted: m = 5039, shift 24, followed by up to two conditional subtractions of q. The result is always below 3329.
- **Ordering:** output beats appear in address order 0..N-1, with `out_last` on index N-1.
- **Handshake:** once `out_valid` is asserted, `out_data` and `out_last` are held stable until the beat is accepted.
- **`start` in RUN or DRAIN:** deassertion is ignored and the unload completes.
- **`start` held high in DONE:** the block stays in DONE. No second unload begins without a new rising edge.
- **Reset at any time:** the block returns to IDLE, the FIFO and pipeline are flushed, and the counters are cleared.

## Timing
- **Reset values:** `ram_rd_en`=0, `ram_rd_addr`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `full_out`=0, `busy`=0.
- **Start to first read:** `start` rises in cycle t. The FSM enters RUN at t+1, and the first `ram_rd_en` is in cycle t+1.
- **First-beat latency:** `ram_rd_en` in cycle c gives `out_valid` for that beat no earlier than c+4, when the FIFO is empty and `out_ready` = 1.
- **Throughput:** with `out_ready` held at 1, the block sustains 1 beat per cycle. All N beats complete N+3 cycles after the first read.
- **`full_out` rise:** asserted in the cycle after the last beat is accepted.
- **`full_out` fall:** deasserted in the cycle after `start` is sampled low in DONE.
- **`busy`:** registered; high from t+1 until the cycle IDLE is re-entered.

## Structure
- **Shared package `kyber_pkg`:** Q = 3329, INV128 = 3303, BARRETT_M = 5039, BARRETT_SH = 24, COEF_W, and the state encoding for this block (one-hot, 4 states).
- **Sub-module `kyber_barrett_reduce`:** a single registered stage taking a 24-bit input and producing COEF_W bits. It is reusable by the NTT and point-wise multiply stages.
- **FIFO:** kept inline as a small register array with pointers and a count; no separate module.

## Test plan
- **Full unload, no backpressure:** RAM holds data = address, `out_ready` = 1, `start` pulses high. Expect 256 beats in order with beat 1 = 3303 and beat 128 = 1. `out_last` is high only on beat 255, and `full_out` rises one cycle after that beat.
- **Arithmetic corners:** inputs 0, 1, 128, 3328, 3329, and 4095 must produce 0, 3303, 1, 26, 0, and 58 respectively. Add random sweeps against a reference model.
- **Backpressure:** drive `out_ready` as a random 30% duty pattern. Check no lost or duplicated beats, `out_data` stable while stalled, and never more than 4 reads outstanding or buffered.
- **`full_out` handshake:** hold `start` high for 20 cycles after completion. `full_out` stays 1 and no new reads occur. `start` falls, then `full_out` = 0 and `busy` = 0 one cycle later. A new rising edge restarts from address 0.
- **Reset mid-operation:** assert `reset` for 1 cycle after beat 100 is accepted. The next cycle shows all outputs at reset values and no pending `out_valid`. A new `start` unloads all 256 beats correctly.
- **Start robustness:** `start` falls during RUN, and separately `start` stays low from reset. The first case still completes all 256 beats. The second produces no reads and keeps `busy` = 0.
